// File: rtl/imem_arbiter_if.sv
// Bus bundle between the two instruction-memory requesters, the arbiter
// and the asynchronous-read instruction memory.
interface imem_arbiter_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 16
);
  logic              f_req;
  logic [ADDR_W-1:0] f_addr;
  logic              f_gnt;
  logic              f_rvalid;
  logic [DATA_W-1:0] f_rdata;

  logic              d_req;
  logic [ADDR_W-1:0] d_addr;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;

  logic              starved;

  // Arbiter side.
  modport slave (
    input  f_req, f_addr, d_req, d_addr, mem_rdata,
    output f_gnt, f_rvalid, f_rdata, d_gnt, d_rvalid, d_rdata,
    output mem_addr, starved
  );

  // Requesters plus memory side.
  modport master (
    output f_req, f_addr, d_req, d_addr, mem_rdata,
    input  f_gnt, f_rvalid, f_rdata, d_gnt, d_rvalid, d_rdata,
    input  mem_addr, starved
  );
endinterface

// File: rtl/imem_arbiter.sv
// Two-port arbiter for the single asynchronous read port of the instruction
// memory. Fetch has fixed priority; a saturating starve counter forces a
// debug grant once debug has lost STARVE_LIMIT consecutive cycles.
// Read data is registered into the winning port one cycle after the grant.
module imem_arbiter #(
  parameter int ADDR_W       = 5,
  parameter int DATA_W       = 16,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          reset,
  imem_arbiter_if.slave bus
);

  localparam logic [3:0] LIMIT   = 4'(STARVE_LIMIT);
  localparam logic [3:0] CNT_MAX = 4'hF;

  logic [3:0]        starve_cnt;
  logic              starved;
  logic              f_gnt;
  logic              d_gnt;
  logic [ADDR_W-1:0] mem_addr;
  logic [ADDR_W-1:0] last_addr;

  logic              f_rvalid_q;
  logic              d_rvalid_q;
  logic [DATA_W-1:0] f_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;

  // Priority decision: forced debug when starved, else fetch, else debug.
  // No grant is issued while reset is asserted.
  always_comb begin
    starved = (starve_cnt >= LIMIT);
    f_gnt   = 1'b0;
    d_gnt   = 1'b0;
    if (!reset) begin
      if (starved && bus.d_req) begin
        d_gnt = 1'b1;
      end else if (bus.f_req) begin
        f_gnt = 1'b1;
      end else if (bus.d_req) begin
        d_gnt = 1'b1;
      end
    end
  end

  // Memory address follows the winner; idle cycles hold the last winner.
  always_comb begin
    mem_addr = last_addr;
    if (reset) begin
      mem_addr = '0;
    end else if (d_gnt) begin
      mem_addr = bus.d_addr;
    end else if (f_gnt) begin
      mem_addr = bus.f_addr;
    end
  end

  // Remember the address presented so idle cycles keep the memory stable.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_addr <= '0;
    end else begin
      last_addr <= mem_addr;
    end
  end

  // Count consecutive cycles debug is pending but loses; any debug grant or
  // dropped request clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (bus.d_req && !d_gnt) begin
      if (starve_cnt != CNT_MAX) begin
        starve_cnt <= starve_cnt + 4'd1;
      end
    end else begin
      starve_cnt <= '0;
    end
  end

  // Capture read data for the winner; rvalid is a one-cycle echo of the grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      f_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      f_rdata_q  <= '0;
      d_rdata_q  <= '0;
    end else begin
      f_rvalid_q <= f_gnt;
      d_rvalid_q <= d_gnt;
      if (f_gnt) begin
        f_rdata_q <= bus.mem_rdata;
      end
      if (d_gnt) begin
        d_rdata_q <= bus.mem_rdata;
      end
    end
  end

  assign bus.f_gnt    = f_gnt;
  assign bus.d_gnt    = d_gnt;
  assign bus.mem_addr = mem_addr;
  assign bus.starved  = starved;
  assign bus.f_rvalid = f_rvalid_q;
  assign bus.d_rvalid = d_rvalid_q;
  assign bus.f_rdata  = f_rdata_q;
  assign bus.d_rdata  = d_rdata_q;

endmodule

// File: tb/tb_imem_arbiter.sv
// Bench for imem_arbiter: directed scenarios plus random traffic, checked
// against an arbitration model and a read-data scoreboard.
module tb_imem_arbiter;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 16;
  localparam int LIMIT  = 4;

  logic clk;
  logic reset;

  imem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  imem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  logic [DATA_W-1:0] mem [32];
  assign bus.mem_rdata = mem[bus.mem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  // Scoreboard entries: {port (1=debug), data}
  logic [DATA_W:0] sb_q [$];

  // Model state
  int                m_cnt  = 0;
  logic [ADDR_W-1:0] m_last = '0;
  logic              m_fv   = 1'b0;
  logic              m_dv   = 1'b0;
  logic [DATA_W-1:0] m_frd  = '0;
  logic [DATA_W-1:0] m_drd  = '0;

  // Monitor: check last cycle's responses, then this cycle's arbitration.
  always @(negedge clk) begin
    logic              e_fg, e_dg, e_st;
    logic [ADDR_W-1:0] e_addr;
    logic [DATA_W:0]   ent;

    chk_eq("f_rvalid", bus.f_rvalid, m_fv);
    chk_eq("d_rvalid", bus.d_rvalid, m_dv);
    if (m_fv || m_dv) begin
      if (sb_q.size() == 0) begin
        chk_eq("sb_underflow", 1, 0);
      end else begin
        ent = sb_q.pop_front();
        if (ent[DATA_W]) m_drd = ent[DATA_W-1:0];
        else             m_frd = ent[DATA_W-1:0];
      end
    end
    chk_eq("f_rdata", bus.f_rdata, m_frd);
    chk_eq("d_rdata", bus.d_rdata, m_drd);

    e_st = (m_cnt >= LIMIT);
    e_fg = 1'b0;
    e_dg = 1'b0;
    if (!reset) begin
      if (e_st && bus.d_req) e_dg = 1'b1;
      else if (bus.f_req)    e_fg = 1'b1;
      else if (bus.d_req)    e_dg = 1'b1;
    end
    e_addr = reset ? '0 : e_dg ? bus.d_addr : e_fg ? bus.f_addr : m_last;

    chk_eq("starved", bus.starved, e_st);
    chk_eq("f_gnt", bus.f_gnt, e_fg);
    chk_eq("d_gnt", bus.d_gnt, e_dg);
    chk_eq("mem_addr", bus.mem_addr, e_addr);

    if (reset) begin
      sb_q.delete();
      m_cnt  = 0;
      m_last = '0;
      m_fv   = 1'b0;
      m_dv   = 1'b0;
      m_frd  = '0;
      m_drd  = '0;
    end else begin
      if (e_fg || e_dg) sb_q.push_back({e_dg, mem[e_addr]});
      m_fv   = e_fg;
      m_dv   = e_dg;
      m_last = e_addr;
      if (bus.d_req && !e_dg) m_cnt = (m_cnt < 15) ? m_cnt + 1 : 15;
      else                    m_cnt = 0;
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 16'(i * 16'h0101) ^ 16'h5A00;
    mem[0]  = 16'h3004;
    mem[1]  = 16'h3105;
    mem[20] = 16'hFFFF;

    reset      = 1'b1;
    bus.f_req  = 1'b0;
    bus.f_addr = '0;
    bus.d_req  = 1'b0;
    bus.d_addr = '0;
    cyc(2);
    reset = 1'b0;
    cyc(1);

    // Back-to-back fetches
    bus.f_req  = 1'b1;
    bus.f_addr = 5'd0;
    cyc(1);
    bus.f_addr = 5'd1;
    cyc(1);
    bus.f_req = 1'b0;
    @(negedge clk);
    chk_eq("fetch1_data", bus.f_rdata, 16'h3105);
    cyc(1);

    // Contention: fetch held, debug forced after LIMIT losses
    bus.f_req  = 1'b1;
    bus.f_addr = 5'd0;
    bus.d_req  = 1'b1;
    bus.d_addr = 5'd20;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk_eq("dgnt_idx", bus.d_gnt, (i == LIMIT));
      chk_eq("fgnt_idx", bus.f_gnt, (i != LIMIT));
      if (i == LIMIT + 1) begin
        chk_eq("dbg_rvalid", bus.d_rvalid, 1);
        chk_eq("dbg_rdata", bus.d_rdata, 16'hFFFF);
      end
      cyc(1);
      if (i == LIMIT) bus.d_req = 1'b0;
    end
    bus.f_req = 1'b0;
    cyc(1);

    // Debug alone
    bus.d_req  = 1'b1;
    bus.d_addr = 5'd1;
    @(negedge clk);
    chk_eq("dbg_alone_gnt", bus.d_gnt, 1);
    cyc(1);
    bus.d_req = 1'b0;
    @(negedge clk);
    chk_eq("dbg_alone_data", bus.d_rdata, 16'h3105);
    cyc(1);

    // Reset in the cycle after a fetch grant
    bus.f_req  = 1'b1;
    bus.f_addr = 5'd0;
    cyc(1);
    bus.f_req = 1'b0;
    reset     = 1'b1;
    cyc(1);
    reset = 1'b0;
    @(negedge clk);
    chk_eq("post_rst_fv", bus.f_rvalid, 0);
    chk_eq("post_rst_fd", bus.f_rdata, 0);
    bus.f_req  = 1'b1;
    bus.f_addr = 5'd1;
    cyc(1);
    bus.f_req = 1'b0;
    cyc(2);

    // Random traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      reset      = ($urandom_range(0, 49) == 0);
      bus.f_req  = ($urandom_range(0, 3) != 0);
      bus.d_req  = ($urandom_range(0, 2) != 0);
      bus.f_addr = 5'($urandom_range(0, 31));
      bus.d_addr = 5'($urandom_range(0, 31));
      cyc(1);
    end
    reset     = 1'b0;
    bus.f_req = 1'b0;
    bus.d_req = 1'b0;
    cyc(3);
    chk_eq("sb_drained", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/imem_arbiter.md
Name: imem_arbiter

Overview:
Shares the single asynchronous read port of the 32x16 instruction memory between two requesters.
- Port 0 is core fetch.
- Port 1 is a debug/readback master.
Fixed priority goes to fetch, with a starvation guard that forces a debug grant after a bounded wait. Read data is registered, so every grant returns data exactly one cycle later on the winning port.

Parameters:
ADDR_W, 5, word address width of the instruction memory
DATA_W, 16, instruction word width
STARVE_LIMIT, 4, consecutive cycles of pending-but-ungranted debug request before debug is forced to win (legal 1..15)

Ports:
clk  input  1  single clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
f_req  input  1  fetch read request; held with f_addr until f_gnt
f_addr  input  ADDR_W  fetch word address
f_gnt  output  1  fetch granted this cycle (combinational)
f_rvalid  output  1  fetch read data valid (registered)
f_rdata  output  DATA_W  fetch read data
d_req  input  1  debug read request; held with d_addr until d_gnt
d_addr  input  ADDR_W  debug word address
d_gnt  output  1  debug granted this cycle (combinational)
d_rvalid  output  1  debug read data valid (registered)
d_rdata  output  DATA_W  debug read data
mem_addr  output  ADDR_W  to instruction memory read address
mem_rdata  input  DATA_W  from instruction memory read data (combinational)
starved  output  1  debug priority override active this cycle

Behaviour:
- Reset (reset=1 at a clk edge):
  - starve counter=0; f_rvalid=0, d_rvalid=0.
  - f_rdata=0, d_rdata=0.
  - During the reset cycle, f_gnt=0 and d_gnt=0; mem_addr=0.
- Arbitration (combinational, each cycle):
  - starved = (starve_cnt >= STARVE_LIMIT).
  - If starved and d_req: d_gnt=1, f_gnt=0.
  - Else if f_req: f_gnt=1.
  - Else if d_req: d_gnt=1.
  - Else no grant.
  - At most one grant per cycle; f_gnt&d_gnt never both 1.
- mem_addr: the winner's address. With no grant it holds the previous registered winner address; after reset it is 0.
- Response: at the edge ending a grant cycle, mem_rdata is captured into the winner's rdata register, and that port's rvalid=1 for exactly the next cycle. The other port's rvalid=0.
- rdata registers hold their last value until the next capture for that port.
- Latency: grant cycle T -> rvalid/rdata at T+1. Back-to-back grants to one port give continuous rvalid with one word per cycle.
- Starve counter:
  - Increments (saturating at 15) each cycle d_req=1 and d_gnt=0.
  - Clears to 0 on any d_gnt, or when d_req=0.
- Requester rule: req/addr must stay stable from assertion until the gnt cycle. Address changes before grant are honored as the new address, with no error flagged.
- Simultaneous f_req and d_req with starve_cnt<STARVE_LIMIT: fetch wins and debug waits.
- Continuous f_req with d_req held:
  - Debug is granted on the cycle after STARVE_LIMIT consecutive losses, i.e. its (STARVE_LIMIT+1)-th pending cycle.
  - Fetch stalls for that one cycle (f_gnt=0).
- Reset mid-operation:
  - Any pending rvalid is dropped; rvalid is 0 the cycle after reset.
  - The counter clears; no grant is issued in the reset cycle.
- No internal buffering: an ungranted request is not remembered; the requester keeps req high.

Test Plan:
- Memory model preloaded with word0=16'h3004, word1=16'h3105, word20=16'hFFFF. Reset held 2 cycles -> all outputs 0; f_rvalid=d_rvalid=0 the cycle after release.
- f_req=1 with f_addr=0 then 1 in consecutive cycles, d_req=0 -> f_gnt=1 both cycles; f_rdata=16'h3004 then 16'h3105 on the following cycles with f_rvalid=1, d_rvalid=0.
- f_req=1 (addr 0) and d_req=1 (addr 20) asserted together -> cycle 0 f_gnt.
- Same stimulus, f_req held continuously, STARVE_LIMIT=4 -> f_gnt cycles 0-3, starved=1 and d_gnt=1 at cycle 4, d_rdata=16'hFFFF with d_rvalid=1 at cycle 5, f_gnt resumes at cycle 5, counter back to 0.
- d_req alone, addr 1 -> d_gnt same cycle, d_rdata=16'h3105 next cycle; starve counter stays 0.
- Assert reset in the cycle after an f_gnt -> f_rvalid=0 the cycle after reset, f_rdata=0, no grant during reset. The first post-reset request is served normally.
